// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Brief    : Fetch stage. It drives one outstanding request, presents fetched
//            words to decode, and has a one-entry skid buffer plus a drain on
//            redirect. Define FETCH_STAT_EN to add the o_fetch_count output.
// Revision : 1.0
// ============================================================================
module inst_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_flush_target,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [DATA_W-1:0] i_imem_data,
  output logic [ADDR_W-1:0] o_program_counter,
  output logic [DATA_W-1:0] o_instruction,
  output logic              o_inst_valid
`ifdef FETCH_STAT_EN
  ,
  output logic [31:0]       o_fetch_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_pend_target;
  logic [ADDR_W-1:0] r_skid_pc;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_skid_valid;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_inst;
  logic              r_valid;

  logic w_req;
  logic w_ack;
  logic w_out_mem;
  logic w_skid_fill;
  logic w_skid_pop;
  logic w_out_clr;
  logic w_pc_adv;
  logic w_pc_redir;
  logic w_pc_pend;
  logic w_tgt_hold;

  // Request is a pure function of registers, so it drops the instant reset asserts.
  assign w_req = ((r_state == S_FETCH) || (r_state == S_DRAIN)) && !r_skid_valid;
  assign w_ack = i_imem_ack && w_req;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_out_mem   = 1'b0;
    w_skid_fill = 1'b0;
    w_skid_pop  = 1'b0;
    w_out_clr   = 1'b0;
    w_pc_adv    = 1'b0;
    w_pc_redir  = 1'b0;
    w_pc_pend   = 1'b0;
    w_tgt_hold  = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (!i_flush) begin
          if (w_ack) begin
            w_pc_adv = 1'b1;
            if (i_stall && r_valid) w_skid_fill = 1'b1;
            else                    w_out_mem   = 1'b1;
          end else if (!i_stall) begin
            if (r_skid_valid) w_skid_pop = 1'b1;
            else              w_out_clr  = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (w_ack) begin
          w_state_nxt = S_FETCH;
          w_pc_pend   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A redirect with a request still in flight must keep the old address
    // until memory answers, so the target is parked instead.
    if (i_flush) begin
      w_out_clr = 1'b1;
      if (w_req && !w_ack) begin
        w_state_nxt = S_DRAIN;
        w_tgt_hold  = 1'b1;
      end else begin
        w_state_nxt = S_FETCH;
        w_pc_redir  = 1'b1;
        w_pc_pend   = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_pc    <= '0;
      r_pend_target <= '0;
      r_skid_pc     <= '0;
      r_skid_data   <= '0;
      r_skid_valid  <= 1'b0;
      r_pc          <= '0;
      r_inst        <= '0;
      r_valid       <= 1'b0;
    end else begin
      if (w_pc_redir)     r_fetch_pc <= i_flush_target;
      else if (w_pc_pend) r_fetch_pc <= r_pend_target;
      else if (w_pc_adv)  r_fetch_pc <= r_fetch_pc + ADDR_W'(4);

      if (w_tgt_hold) r_pend_target <= i_flush_target;

      if (i_flush || w_skid_pop) begin
        r_skid_valid <= 1'b0;
      end else if (w_skid_fill) begin
        r_skid_pc    <= r_fetch_pc;
        r_skid_data  <= i_imem_data;
        r_skid_valid <= 1'b1;
      end

      if (w_out_mem) begin
        r_pc    <= r_fetch_pc;
        r_inst  <= i_imem_data;
        r_valid <= 1'b1;
      end else if (w_skid_pop) begin
        r_pc    <= r_skid_pc;
        r_inst  <= r_skid_data;
        r_valid <= 1'b1;
      end else if (w_out_clr) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_STAT_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_count <= '0;
    end else if (w_out_mem || w_skid_pop) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign o_fetch_count = r_fetch_count;
`endif

  assign o_imem_req        = w_req;
  assign o_imem_addr       = r_fetch_pc;
  assign o_program_counter = r_pc;
  assign o_instruction     = r_inst;
  assign o_inst_valid      = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Brief    : Directed vector table, reset corner cases and a randomized run
//            against a transaction-level fetch model. Define FETCH_STAT_EN to
//            also check o_fetch_count.
// Revision : 1.0
// ============================================================================
module tb_inst_fetch;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] tgt = '0;
  logic [31:0] data = '0;
  logic        req;
  logic [31:0] addr;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        valid;
`ifdef FETCH_STAT_EN
  logic [31:0] fcount;
`endif

  int errors = 0;
  int checks = 0;

  inst_fetch dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_stall           (stall),
    .i_flush           (flush),
    .i_flush_target    (tgt),
    .o_imem_req        (req),
    .o_imem_addr       (addr),
    .i_imem_ack        (ack),
    .i_imem_data       (data),
    .o_program_counter (pc),
    .o_instruction     (inst),
    .o_inst_valid      (valid)
`ifdef FETCH_STAT_EN
    ,
    .o_fetch_count     (fcount)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        flush;
    logic        ack;
    logic [31:0] tgt;
    logic [31:0] data;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    int unsigned cnt;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic f, input logic a,
                              input logic [31:0] t, input logic [31:0] d,
                              input logic r, input logic [31:0] ad, input logic v,
                              input logic [31:0] p, input logic [31:0] i,
                              input int unsigned c);
    vec_t x;
    x.stall = s; x.flush = f; x.ack = a; x.tgt = t; x.data = d;
    x.req = r; x.addr = ad; x.valid = v; x.pc = p; x.inst = i; x.cnt = c;
    return x;
  endfunction

  // Transaction-level reference: the skid is a queue, the drain a flag.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } item_t;

  bit          m_run;
  bit          m_drain;
  logic [31:0] m_pc;
  logic [31:0] m_target;
  bit          m_ov;
  logic [31:0] m_opc;
  logic [31:0] m_oinst;
  int unsigned m_cnt;
  item_t       m_skid[$];

  task automatic m_reset();
    m_run = 0; m_drain = 0; m_pc = '0; m_target = '0;
    m_ov = 0; m_opc = '0; m_oinst = '0; m_cnt = 0;
    m_skid.delete();
  endtask

  function automatic bit m_req();
    return m_run && (m_skid.size() == 0);
  endfunction

  task automatic m_step(input bit s, input bit f, input bit a,
                        input logic [31:0] t, input logic [31:0] d);
    bit    r;
    bit    got;
    item_t it;
    r   = m_req();
    got = a && r;
    if (f) begin
      m_ov = 0;
      m_skid.delete();
      if (got || !r) begin
        m_pc = t; m_drain = 0;
      end else begin
        m_target = t; m_drain = 1;
      end
    end else if (m_drain) begin
      if (got) begin
        m_pc = m_target; m_drain = 0;
      end
    end else if (got) begin
      if (s && m_ov) begin
        it.pc = m_pc; it.data = d;
        m_skid.push_back(it);
      end else begin
        m_opc = m_pc; m_oinst = d; m_ov = 1; m_cnt++;
      end
      m_pc = m_pc + 32'd4;
    end else if (!s) begin
      if (m_skid.size() != 0) begin
        it = m_skid.pop_front();
        m_opc = it.pc; m_oinst = it.data; m_ov = 1; m_cnt++;
      end else begin
        m_ov = 0;
      end
    end
    m_run = 1;
  endtask

  vec_t vecs[22];

  initial begin
    // stall flush ack tgt data | req addr valid pc inst cnt
    vecs[0]  = mk(N,N,Y,32'h0,32'h1000,         N,32'h0,N,32'h0,32'h0,0);
    vecs[1]  = mk(N,N,Y,32'h0,32'h1000,         Y,32'h0,N,32'h0,32'h0,0);
    vecs[2]  = mk(N,N,Y,32'h0,32'h1004,         Y,32'h4,Y,32'h0,32'h1000,1);
    vecs[3]  = mk(N,N,Y,32'h0,32'h1008,         Y,32'h8,Y,32'h4,32'h1004,2);
    vecs[4]  = mk(Y,N,Y,32'h0,32'h100C,         Y,32'hC,Y,32'h8,32'h1008,3);
    vecs[5]  = mk(Y,N,Y,32'h0,32'hDEAD0000,     N,32'h10,Y,32'h8,32'h1008,3);
    vecs[6]  = mk(Y,N,Y,32'h0,32'hDEAD0004,     N,32'h10,Y,32'h8,32'h1008,3);
    vecs[7]  = mk(N,N,Y,32'h0,32'hDEAD0008,     N,32'h10,Y,32'h8,32'h1008,3);
    vecs[8]  = mk(N,Y,Y,32'h100,32'h1010,       Y,32'h10,Y,32'hC,32'h100C,4);
    vecs[9]  = mk(N,N,Y,32'h0,32'h1100,         Y,32'h100,N,32'h0,32'h0,4);
    vecs[10] = mk(N,Y,N,32'h200,32'h0,          Y,32'h104,Y,32'h100,32'h1100,5);
    vecs[11] = mk(N,N,N,32'h0,32'h0,            Y,32'h104,N,32'h0,32'h0,5);
    vecs[12] = mk(N,N,N,32'h0,32'h0,            Y,32'h104,N,32'h0,32'h0,5);
    vecs[13] = mk(N,N,Y,32'h0,32'hBAD0BAD0,     Y,32'h104,N,32'h0,32'h0,5);
    vecs[14] = mk(N,N,Y,32'h0,32'h1200,         Y,32'h200,N,32'h0,32'h0,5);
    vecs[15] = mk(N,N,N,32'h0,32'h0,            Y,32'h204,Y,32'h200,32'h1200,6);
    vecs[16] = mk(Y,N,Y,32'h0,32'h1204,         Y,32'h204,N,32'h0,32'h0,6);
    vecs[17] = mk(N,N,N,32'h0,32'h0,            Y,32'h208,Y,32'h204,32'h1204,7);
    vecs[18] = mk(N,Y,Y,32'hFFFFFFFC,32'hBAD,   Y,32'h208,N,32'h0,32'h0,7);
    vecs[19] = mk(N,N,Y,32'h0,32'h12345678,     Y,32'hFFFFFFFC,N,32'h0,32'h0,7);
    vecs[20] = mk(N,N,N,32'h0,32'h0,            Y,32'h0,Y,32'hFFFFFFFC,32'h12345678,8);
    vecs[21] = mk(N,N,N,32'h0,32'h0,            Y,32'h0,N,32'h0,32'h0,8);

    rst_n = 1'b0;
    ack   = 1'b1;
    repeat (2) @(negedge clk);
    chk1("rst.req", req, 1'b0);
    chk ("rst.addr", addr, 32'h0);
    chk1("rst.valid", valid, 1'b0);
    chk ("rst.pc", pc, 32'h0);
    chk ("rst.inst", inst, 32'h0);
`ifdef FETCH_STAT_EN
    chk ("rst.cnt", fcount, 32'h0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      chk1($sformatf("v%0d.req", i), req, vecs[i].req);
      chk ($sformatf("v%0d.addr", i), addr, vecs[i].addr);
      chk1($sformatf("v%0d.valid", i), valid, vecs[i].valid);
      if (vecs[i].valid) begin
        chk($sformatf("v%0d.pc", i), pc, vecs[i].pc);
        chk($sformatf("v%0d.inst", i), inst, vecs[i].inst);
      end
`ifdef FETCH_STAT_EN
      chk($sformatf("v%0d.cnt", i), fcount, vecs[i].cnt);
`endif
      stall = vecs[i].stall;
      flush = vecs[i].flush;
      ack   = vecs[i].ack;
      tgt   = vecs[i].tgt;
      data  = vecs[i].data;
      @(negedge clk);
    end

    // Reset in the middle of a cycle with a live request and a valid output.
    ack  = 1'b1;
    data = 32'h55;
    @(negedge clk);
    chk1("pre_rst.valid", valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("async_rst.req", req, 1'b0);
    chk1("async_rst.valid", valid, 1'b0);
    chk ("async_rst.addr", addr, 32'h0);
    chk ("async_rst.pc", pc, 32'h0);
    @(negedge clk);
    ack   = 1'b0;
    rst_n = 1'b1;
    m_reset();

    for (int n = 0; n < 3000; n++) begin
      chk1("rnd.req", req, m_req());
      chk ("rnd.addr", addr, m_pc);
      chk1("rnd.valid", valid, m_ov);
      if (m_ov) begin
        chk("rnd.pc", pc, m_opc);
        chk("rnd.inst", inst, m_oinst);
      end
`ifdef FETCH_STAT_EN
      chk("rnd.cnt", fcount, m_cnt);
`endif
      stall = ($urandom_range(0, 99) < ((n % 600) < 300 ? 20 : 60));
      flush = ($urandom_range(0, 99) < 8);
      ack   = ($urandom_range(0, 99) < 55);
      tgt   = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC : ($urandom() & 32'hFFFF_FFFC);
      data  = $urandom();
      m_step(stall, flush, ack, tgt, data);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 stall  in  1  downstream decode stage holds; the output register SHALL keep its value.
REQ-005 flush  in  1  redirect request; takes priority over stall and ack.
REQ-006 flush_target  in  `INST_ADDR_BUS (32)  next fetch address on flush; word aligned by the caller.
REQ-007 imem_req  out  1  instruction-memory request, level-held until ack.
REQ-008 imem_addr  out  32  request address; stable while imem_req is high.
REQ-009 imem_ack  in  1  single-cycle completion, sampled only while imem_req is high.
REQ-010 imem_data  in  `INST_DATA_BUS (32)  instruction word, valid in the ack cycle.
REQ-011 program_counter  out  32  address of the presented instruction, feeds decode.
REQ-012 instruction  out  32  presented instruction word, feeds decode.
REQ-013 inst_valid  out  1  program_counter and instruction are valid.

Function
REQ-014 The block SHALL contain an internal fetch_pc, a one-entry skid buffer (pc, data, valid) and a state machine with states IDLE, FETCH and DRAIN.
REQ-015 The block SHALL move from IDLE to FETCH on the first clock edge after reset release.
REQ-016 imem_req SHALL be driven from registers only, as (state==FETCH or state==DRAIN) and skid empty.
REQ-017 imem_addr SHALL equal fetch_pc.
REQ-018 In FETCH, an ack with flush=0 and stall=0 SHALL load {fetch_pc, imem_data, 1} into the output register at that edge, with fetch_pc += 4 (modulo 2^32; 0xFFFFFFFC wraps to 0).
REQ-019 In FETCH, an ack with stall=1 SHALL load the skid buffer, leave the output register unchanged and advance fetch_pc by 4.
REQ-020 A skid fill SHALL occur only when the output register is valid; if it is invalid, the ack SHALL load the output register despite stall.
REQ-021 A non-stalled cycle with a valid skid SHALL move the skid into the output register and clear the skid; imem_req then reasserts on the following cycle.
REQ-022 A non-stalled cycle with no new data SHALL clear inst_valid, since decode consumes one instruction per non-stalled cycle.
REQ-023 flush=1 SHALL clear inst_valid and the skid valid, and load fetch_pc with flush_target.
REQ-024 If flush=1 coincides with ack, or no request is pending, state SHALL be FETCH next cycle, with the ack data discarded.
REQ-025 If flush=1 occurs while imem_req is high without ack, state SHALL go to DRAIN.
REQ-026 In DRAIN, imem_addr SHALL hold the old address until ack; the ack data SHALL be discarded, then state goes to FETCH with imem_addr = flush_target.
REQ-027 A flush during DRAIN SHALL only update the pending target.
REQ-028 At most one request SHALL be outstanding; an ack while imem_req is low SHALL be ignored.

Reset
REQ-029 Reset asserted SHALL immediately force: state IDLE, fetch_pc 0x00000000, imem_req 0, imem_addr 0, program_counter 0, instruction 0, inst_valid 0, skid cleared, and fetch_count 0 where present.
REQ-030 Reset during an outstanding request SHALL abandon it; the memory SHALL tolerate a dropped imem_req.

Configuration
REQ-031 With macro FETCH_STAT_EN defined, the block SHALL add output fetch_count (32 bits), incremented on each instruction entering the output register from memory or skid, wrapping modulo 2^32.
REQ-032 Discarded and flushed data SHALL NOT be counted in fetch_count.
REQ-033 Without FETCH_STAT_EN, neither the port nor the counter SHALL exist.

Verification
REQ-034 Release reset with ack tied to 1 and imem_data = addr + 0x1000: cycle 1 imem_req=0; then program_counter 0, 4, 8 with instruction 0x1000, 0x1004, 0x1008 on consecutive cycles, inst_valid=1 from the second edge.
REQ-035 Hold stall for 3 cycles while program_counter=8: output stays 8, skid takes 0xC, imem_req drops; after release, program_counter=0xC, then imem_addr=0x10 the next cycle.
REQ-036 Assert flush with flush_target=0x100 in the same cycle as ack: next cycle inst_valid=0 and imem_addr=0x100, with no instruction from the ack presented.
REQ-037 Assert flush=0x100 with ack held low 2 more cycles: imem_addr stays at the old value until ack, the data is discarded, then imem_addr=0x100.
REQ-038 Drive reset low mid-request: imem_req=0 and inst_valid=0 without waiting for a clock edge.
REQ-039 With FETCH_STAT_EN: 5 delivered instructions plus 1 flushed ack SHALL give fetch_count=5.
